ex_mem_reg: RTL

EX/MEM pipeline boundary of the r200 five-stage RV32I core: captures the EX-stage result bundle (ALU result, store data, destination register, write-back controls) and presents it to the MEM stage. Unlike a plain flop bank, it has a valid/ready handshake and a one-entry skid buffer, so a data-memory stall back-pressures EX without dropping an in-flight instruction. A synchronous flush squashes every held entry on a trap.

---
 rtl/ex_mem_reg.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline boundary for the r200 RV32I core: valid/ready handshake with a one-entry skid buffer.
// Define EXMEM_FWD_EN to add the fwd_* bypass outputs sourced from the head entry.
module ex_mem_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_aluout,
  input  logic [31:0] ex_rs2o,
  input  logic [4:0]  ex_rdaddr,
  input  logic        ex_memwr,
  input  logic        ex_regwr,
  input  logic [1:0]  ex_wbsel,
  input  logic [2:0]  ex_func3,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_aluout,
  output logic [31:0] mem_rs2o,
  output logic [4:0]  mem_rdaddr,
  output logic [1:0]  mem_wbsel,
  output logic [2:0]  mem_func3,
  output logic        mem_memwr,
  output logic        mem_regwr
`ifdef EXMEM_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rdaddr,
  output logic [31:0] fwd_data
`endif
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RAW  = 5;

  typedef struct packed {
    logic [XLEN-1:0] aluout;
    logic [XLEN-1:0] rs2o;
    logic [RAW-1:0]  rdaddr;
    logic            memwr;
    logic            regwr;
    logic [1:0]      wbsel;
    logic [2:0]      func3;
  } bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t  state_q, state_d;
  bundle_t head_q, head_d;
  bundle_t skid_q, skid_d;
  logic    ex_ready_q, ex_ready_d;
  logic    mem_valid_q, mem_valid_d;

  bundle_t ex_bundle;
  logic    accept;
  logic    consume;

  assign ex_bundle = '{aluout: ex_aluout, rs2o: ex_rs2o, rdaddr: ex_rdaddr,
                       memwr: ex_memwr, regwr: ex_regwr, wbsel: ex_wbsel,
                       func3: ex_func3};

  // Handshake qualifiers use the registered ready/valid so mem_ready never reaches ex_ready.
  assign accept  = ex_valid & ex_ready_q & ~flush;
  assign consume = mem_valid_q & mem_ready;

  // Next-state and entry movement; flush drops both entries but leaves data fields untouched.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    skid_d      = skid_q;
    ex_ready_d  = ex_ready_q;
    mem_valid_d = mem_valid_q;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_d  = ex_bundle;
            state_d = FULL;
          end
        end
        FULL: begin
          if (accept && consume) begin
            head_d = ex_bundle;
          end else if (consume) begin
            state_d = EMPTY;
          end else if (accept) begin
            skid_d  = ex_bundle;
            state_d = SKID;
          end
        end
        SKID: begin
          if (consume) begin
            head_d  = skid_q;
            state_d = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    ex_ready_d  = (state_d != SKID);
    mem_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      ex_ready_q  <= 1'b1;
      mem_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      ex_ready_q  <= ex_ready_d;
      mem_valid_q <= mem_valid_d;
    end
  end

  assign ex_ready   = ex_ready_q;
  assign mem_valid  = mem_valid_q;
  assign mem_aluout = head_q.aluout;
  assign mem_rs2o   = head_q.rs2o;
  assign mem_rdaddr = head_q.rdaddr;
  assign mem_wbsel  = head_q.wbsel;
  assign mem_func3  = head_q.func3;

  // Side-effect controls are masked so a stale head can never store or write back.
  assign mem_memwr  = head_q.memwr & mem_valid_q;
  assign mem_regwr  = head_q.regwr & mem_valid_q;

`ifdef EXMEM_FWD_EN
  assign fwd_valid  = mem_valid_q & head_q.regwr & (head_q.rdaddr != RAW'(0));
  assign fwd_rdaddr = head_q.rdaddr;
  assign fwd_data   = head_q.aluout;
`endif

endmodule
